// File: rtl/sw_debounce.sv
// Switch debouncer: a 2-flop synchronizer and a per-bit stability counter,
// with registered rise/fall pulses and a sticky change flag.
module sw_debounce #(
   parameter int SW_WIDTH        = 10,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SW_WIDTH-1:0] sw_raw,
   input  logic                bypass,
   input  logic                evt_clr,
   output logic [SW_WIDTH-1:0] sw_clean,
   output logic [SW_WIDTH-1:0] sw_rise,
   output logic [SW_WIDTH-1:0] sw_fall,
   output logic                sw_event
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SW_WIDTH-1:0] s1;
   logic [SW_WIDTH-1:0] s2;
   logic [SW_WIDTH-1:0] clean_nxt;
   logic [SW_WIDTH-1:0] rise_nxt;
   logic [SW_WIDTH-1:0] fall_nxt;
   logic [CNT_W-1:0]    cnt     [SW_WIDTH];
   logic [CNT_W-1:0]    cnt_nxt [SW_WIDTH];

   // Any edge where the synchronized level matches sw_clean restarts the count.
   always_comb begin
      clean_nxt = sw_clean;
      for (int i = 0; i < SW_WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (bypass) begin
            clean_nxt[i] = s2[i];
         end else if (s2[i] == sw_clean[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CNT_MAX) begin
            clean_nxt[i] = s2[i];
         end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         end
      end
      rise_nxt = clean_nxt & ~sw_clean;
      fall_nxt = ~clean_nxt & sw_clean;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         s2       <= '0;
         sw_clean <= '0;
         sw_rise  <= '0;
         sw_fall  <= '0;
         sw_event <= 1'b0;
         for (int i = 0; i < SW_WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1       <= sw_raw;
         s2       <= s1;
         sw_clean <= clean_nxt;
         sw_rise  <= rise_nxt;
         sw_fall  <= fall_nxt;
         // A new change outranks a clear request on the same edge.
         if (|(rise_nxt | fall_nxt)) begin
            sw_event <= 1'b1;
         end else if (evt_clr) begin
            sw_event <= 1'b0;
         end
         for (int i = 0; i < SW_WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, SW_WIDTH=10.
module tb_sw_debounce;

   localparam int W = 10;
   localparam int D = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] sw_raw;
   logic         bypass;
   logic         evt_clr;
   logic [W-1:0] sw_clean;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         sw_event;

   int total;
   int bad;
   logic [W-1:0] rise_acc;

   sw_debounce #(.SW_WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw),
      .bypass   (bypass),
      .evt_clr  (evt_clr),
      .sw_clean (sw_clean),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall),
      .sw_event (sw_event)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      sw_raw   = '0;
      bypass   = 1'b0;
      evt_clr  = 1'b0;

      // Reset state, observed before any clock edge
      #3;
      chk("rst_clean", 32'(sw_clean), 32'h0);
      chk("rst_rise",  32'(sw_rise),  32'h0);
      chk("rst_fall",  32'(sw_fall),  32'h0);
      chk("rst_event", 32'(sw_event), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Single bit rising, held stable: accepted on edge 6
      sw_raw = 10'h001;
      tick(5);
      chk("t1_clean_e5", 32'(sw_clean), 32'h000);
      chk("t1_rise_e5",  32'(sw_rise),  32'h000);
      tick(1);
      chk("t1_clean_e6", 32'(sw_clean), 32'h001);
      chk("t1_rise_e6",  32'(sw_rise),  32'h001);
      chk("t1_event_e6", 32'(sw_event), 32'h1);
      tick(1);
      chk("t1_rise_e7",  32'(sw_rise),  32'h000);
      chk("t1_clean_e7", 32'(sw_clean), 32'h001);
      evt_clr = 1'b1;
      tick(1);
      evt_clr = 1'b0;
      chk("t1_evt_clr", 32'(sw_event), 32'h0);

      // Short pulse on bit 3 (3 cycles) is rejected
      rise_acc = '0;
      sw_raw = 10'h009;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         rise_acc |= sw_rise;
      end
      sw_raw = 10'h001;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         rise_acc |= sw_rise;
      end
      chk("t2_clean", 32'(sw_clean), 32'h001);
      chk("t2_rise",  32'(rise_acc), 32'h000);
      chk("t2_event", 32'(sw_event), 32'h0);

      // Bit 1 bounces 1,0,1 then stays 1: accepted 6 edges after the last rise
      sw_raw = 10'h003;
      tick(1);
      sw_raw = 10'h001;
      tick(1);
      sw_raw = 10'h003;
      tick(5);
      chk("t3_clean_e5", 32'(sw_clean), 32'h001);
      tick(1);
      chk("t3_clean_e6", 32'(sw_clean), 32'h003);
      chk("t3_rise_e6",  32'(sw_rise),  32'h002);
      evt_clr = 1'b1;
      tick(1);
      evt_clr = 1'b0;

      // Both bits falling together
      sw_raw = 10'h000;
      tick(6);
      chk("t4_fall", 32'(sw_fall), 32'h003);
      chk("t4_rise", 32'(sw_rise), 32'h000);
      evt_clr = 1'b1;
      tick(1);
      evt_clr = 1'b0;
      chk("t4_evt_clr", 32'(sw_event), 32'h0);

      // Bits 0 and 9 together, clear requested on the accept edge: set wins
      sw_raw = 10'h201;
      tick(5);
      evt_clr = 1'b1;
      tick(1);
      evt_clr = 1'b0;
      chk("t5_rise",     32'(sw_rise),  32'h201);
      chk("t5_event",    32'(sw_event), 32'h1);
      tick(1);
      chk("t5_rise_off", 32'(sw_rise),  32'h000);
      chk("t5_event_hold", 32'(sw_event), 32'h1);
      evt_clr = 1'b1;
      tick(1);
      evt_clr = 1'b0;
      chk("t5_evt_clr", 32'(sw_event), 32'h0);

      // Bypass: 3-edge latency both ways, no pulse from leaving bypass
      bypass = 1'b1;
      sw_raw = 10'h3FF;
      tick(3);
      chk("t6_clean_hi", 32'(sw_clean), 32'h3FF);
      chk("t6_rise_hi",  32'(sw_rise),  32'h1FE);
      sw_raw = 10'h000;
      tick(2);
      chk("t6_clean_e2", 32'(sw_clean), 32'h3FF);
      tick(1);
      chk("t6_clean_e3", 32'(sw_clean), 32'h000);
      chk("t6_fall_e3",  32'(sw_fall),  32'h3FF);
      tick(1);
      chk("t6_fall_e4",  32'(sw_fall),  32'h000);
      bypass = 1'b0;
      tick(1);
      chk("t6_exit_rise", 32'(sw_rise | sw_fall), 32'h000);
      chk("t6_exit_clean", 32'(sw_clean), 32'h000);

      // Reset mid-count, then re-acceptance after release
      sw_raw = 10'h001;
      tick(6);
      chk("t7_pre_clean", 32'(sw_clean), 32'h001);
      sw_raw = 10'h011;
      tick(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_async_clean", 32'(sw_clean), 32'h000);
      chk("t7_async_event", 32'(sw_event), 32'h0);
      chk("t7_async_pulse", 32'(sw_rise | sw_fall), 32'h000);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("t7_rel_rise", 32'(sw_rise), 32'h000);
      tick(4);
      chk("t7_clean_e5", 32'(sw_clean), 32'h000);
      tick(1);
      chk("t7_clean_e6", 32'(sw_clean), 32'h011);
      chk("t7_rise_e6",  32'(sw_rise),  32'h011);
      chk("t7_event_e6", 32'(sw_event), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
